clk_run_ctrl: RTL and testbench

- Run-control stage directly upstream of the divided-clock generator; produces its `active` enable.
- Debounces the board start/stop buttons and runs a start/stop state machine.
- Detects processor completion, which arrives from the divided-clock domain.
- Enforces a watchdog cycle budget and counts run cycles for the debug readout.

---
 rtl/clk_run_ctrl.sv | 156 +++++++++++++++
 tb/tb_clk_run_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_run_ctrl.sv
// Run-control stage feeding the divided-clock generator: button debounce,
// start/stop FSM, completion detect, watchdog and run-cycle counter.

module clk_run_debounce #(
    parameter logic [15:0] CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic accepted
);
    logic [15:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            accepted <= 1'b0;
        end else if (level != accepted) begin
            if (cnt == CYCLES - 16'd1) begin
                accepted <= level;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            cnt <= '0;
        end
    end
endmodule

module clk_run_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd100000000,
    parameter int          CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             proc_done,
    output logic             active,
    output logic             busy,
    output logic             finished,
    output logic             timed_out,
    output logic             aborted,
    output logic [CNT_W-1:0] run_cycles
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state;
    logic [2:0] sync_meta;
    logic [2:0] sync_q;
    logic       done_d;
    logic       start_acc;
    logic       stop_acc;
    logic       start_acc_d;
    logic       stop_acc_d;
    logic       start_ev;
    logic       stop_ev;
    logic       done_ev;

    // Bit order: {proc_done, stop_btn, start_btn}; proc_done crosses from the divided domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta   <= '0;
            sync_q      <= '0;
            done_d      <= 1'b0;
            start_acc_d <= 1'b0;
            stop_acc_d  <= 1'b0;
        end else begin
            sync_meta   <= {proc_done, stop_btn, start_btn};
            sync_q      <= sync_meta;
            done_d      <= sync_q[2];
            start_acc_d <= start_acc;
            stop_acc_d  <= stop_acc;
        end
    end

    clk_run_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .level    (sync_q[0]),
        .accepted (start_acc)
    );

    clk_run_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_stop_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .level    (sync_q[1]),
        .accepted (stop_acc)
    );

    assign start_ev = start_acc & ~start_acc_d;
    assign stop_ev  = stop_acc & ~stop_acc_d;
    assign done_ev  = sync_q[2] & ~done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            active     <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            timed_out  <= 1'b0;
            aborted    <= 1'b0;
            run_cycles <= '0;
        end else begin
            finished <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ev) begin
                        state      <= RUN;
                        active     <= 1'b1;
                        busy       <= 1'b1;
                        run_cycles <= '0;
                        timed_out  <= 1'b0;
                        aborted    <= 1'b0;
                    end
                end
                RUN: begin
                    if (run_cycles != CNT_MAX) begin
                        run_cycles <= run_cycles + 1'b1;
                    end
                    // Exactly one exit cause is flagged: stop beats done beats watchdog.
                    if (stop_ev) begin
                        state   <= HALT;
                        active  <= 1'b0;
                        aborted <= 1'b1;
                    end else if (done_ev) begin
                        state    <= HALT;
                        active   <= 1'b0;
                        finished <= 1'b1;
                    end else if (run_cycles == WDOG_LAST) begin
                        state     <= HALT;
                        active    <= 1'b0;
                        timed_out <= 1'b1;
                    end
                end
                HALT: begin
                    if (!start_acc) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clk_run_ctrl.sv
// Scoreboard bench for clk_run_ctrl: stimulus queues the expected end-of-run
// result, a monitor compares it when the DUT drops active.

module tb_clk_run_ctrl;
    localparam int CNT_W = 32;

    typedef struct {
        logic [CNT_W-1:0] cycles;
        logic             tmo;
        logic             abt;
        logic             fin;
    } run_exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_btn = 1'b0;
    logic             stop_btn = 1'b0;
    logic             proc_done = 1'b0;
    logic             active;
    logic             busy;
    logic             finished;
    logic             timed_out;
    logic             aborted;
    logic [CNT_W-1:0] run_cycles;

    int       checks = 0;
    int       errors = 0;
    int       fin_seen = 0;
    run_exp_t sb[$];

    clk_run_ctrl #(
        .DEBOUNCE_CYCLES (16'd8),
        .TIMEOUT_CYCLES  (32'd1000),
        .CNT_W           (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_btn  (start_btn),
        .stop_btn   (stop_btn),
        .proc_done  (proc_done),
        .active     (active),
        .busy       (busy),
        .finished   (finished),
        .timed_out  (timed_out),
        .aborted    (aborted),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_active(input logic lvl, input int max, output int n);
        n = 0;
        while (active !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        if (active !== lvl) check("wait_active_timeout", 64'(n), 64'(max + 1));
    endtask

    task automatic push_exp(input int cyc, input logic tmo, input logic abt, input logic fin);
        run_exp_t e;
        e.cycles = CNT_W'(cyc);
        e.tmo    = tmo;
        e.abt    = abt;
        e.fin    = fin;
        sb.push_back(e);
    endtask

    // Monitor: a falling active edge marks the end of a run.
    initial begin : monitor
        logic     prev_active;
        int       act_cycles;
        run_exp_t e;
        prev_active = 1'b0;
        act_cycles  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_active = 1'b0;
                act_cycles  = 0;
            end else begin
                if (finished === 1'b1) fin_seen++;
                if (active === 1'b1) act_cycles++;
                if (prev_active && active === 1'b0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_run_end", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("run_cycles", 64'(run_cycles), 64'(e.cycles));
                        check("active_duration", 64'(act_cycles), 64'(e.cycles));
                        check("timed_out", 64'(timed_out), 64'(e.tmo));
                        check("aborted", 64'(aborted), 64'(e.abt));
                        check("finished", 64'(finished), 64'(e.fin));
                    end
                    act_cycles = 0;
                end
                prev_active = active;
            end
        end
    end

    initial begin : stimulus
        int n;
        logic stayed_low;

        // Reset state
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_active", 64'(active), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_finished", 64'(finished), 64'd0);
        check("rst_timed_out", 64'(timed_out), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_run_cycles", 64'(run_cycles), 64'd0);

        // Bouncing start button: no run until the level is stable
        stayed_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start_btn = ~start_btn;
            repeat (3) begin
                @(negedge clk);
                if (active !== 1'b0) stayed_low = 1'b0;
            end
        end
        check("bounce_no_run", 64'(stayed_low), 64'd1);
        start_btn = 1'b1;
        wait_active(1'b1, 40, n);
        check("start_latency", 64'(n), 64'd11);

        // Normal completion by proc_done
        push_exp(503, 1'b0, 1'b0, 1'b1);
        repeat (500) @(negedge clk);
        proc_done = 1'b1;
        wait_active(1'b0, 20, n);
        check("done_latency", 64'(n), 64'd3);
        repeat (5) @(negedge clk);
        check("halt_held_busy", 64'(busy), 64'd1);
        check("halt_held_active", 64'(active), 64'd0);
        check("finished_one_cycle", 64'(fin_seen), 64'd1);
        start_btn = 1'b0;
        proc_done = 1'b0;
        repeat (15) @(negedge clk);
        check("idle_after_release", 64'(busy), 64'd0);

        // Watchdog expiry
        start_btn = 1'b1;
        wait_active(1'b1, 40, n);
        push_exp(1000, 1'b1, 1'b0, 1'b0);
        wait_active(1'b0, 1100, n);
        check("timeout_duration", 64'(n), 64'd1000);
        start_btn = 1'b0;
        repeat (15) @(negedge clk);
        check("idle_after_timeout", 64'(busy), 64'd0);

        // Coincident stop_ev and done_ev; stop wins
        start_btn = 1'b1;
        wait_active(1'b1, 40, n);
        check("timed_out_cleared", 64'(timed_out), 64'd0);
        push_exp(31, 1'b0, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        stop_btn = 1'b1;
        repeat (8) @(negedge clk);
        proc_done = 1'b1;
        wait_active(1'b0, 40, n);
        repeat (30) @(negedge clk);
        check("halt_hold_busy", 64'(busy), 64'd1);
        check("halt_hold_active", 64'(active), 64'd0);
        check("halt_hold_aborted", 64'(aborted), 64'd1);
        check("no_finished_on_abort", 64'(fin_seen), 64'd1);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        proc_done = 1'b0;
        repeat (15) @(negedge clk);
        check("idle_after_abort", 64'(busy), 64'd0);

        // Asynchronous reset mid-run
        start_btn = 1'b1;
        wait_active(1'b1, 40, n);
        repeat (200) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        start_btn = 1'b0;
        #1;
        check("async_rst_active", 64'(active), 64'd0);
        check("async_rst_run_cycles", 64'(run_cycles), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // stop in IDLE is ignored
        stop_btn = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_stop_no_flag", 64'(aborted), 64'd0);
        check("idle_stop_no_run", 64'(busy), 64'd0);
        stop_btn = 1'b0;
        repeat (20) @(negedge clk);

        // Fresh run after reset, ended by stop
        start_btn = 1'b1;
        wait_active(1'b1, 40, n);
        check("post_rst_start_latency", 64'(n), 64'd11);
        push_exp(111, 1'b0, 1'b1, 1'b0);
        repeat (100) @(negedge clk);
        stop_btn = 1'b1;
        wait_active(1'b0, 40, n);
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("finished_total", 64'(fin_seen), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
